branch_resolve_queue: RTL and testbench

Tracks every conditional branch from fetch (where the predictor issues its guess) until execute resolves it. It holds the guess, PC and predicted target in a small in-order queue, and checks each guess against the actual outcome. It then emits the one-cycle `taken`/`not_taken` training pulses that drive the branch predictor's saturating counters, plus a mispredict flush and redirect PC for fetch.

---
 rtl/branch_resolve_queue.sv | 124 ++++++++++++
 tb/tb_branch_resolve_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// In-order branch tracking queue: checks each prediction at resolve time and emits
// predictor training pulses plus mispredict flush/redirect. Optional macro: BR_RESOLVE_STATS_EN.
module branch_resolve_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [15:0]              push_pc,
  input  logic                     push_pred,
  input  logic [15:0]              push_target,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic [15:0]              resolve_target,
  output logic                     taken,
  output logic                     not_taken,
  output logic                     mispredict,
  output logic [15:0]              redirect_pc,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow_err,
  output logic [15:0]              stat_resolved,
  output logic [15:0]              stat_mispredict
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [15:0]   r_pc   [DEPTH];
  logic          r_pred [DEPTH];
  logic [15:0]   r_tgt  [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_full;
  logic          w_do_resolve;
  logic          w_wrong;
  logic          w_flush;
  logic          w_pop;
  logic          w_do_push;
  logic [15:0]   w_head_pc;
  logic          w_head_pred;
  logic [15:0]   w_head_tgt;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_head_pc    = r_pc[r_rd];
  assign w_head_pred  = r_pred[r_rd];
  assign w_head_tgt   = r_tgt[r_rd];
  assign w_do_resolve = resolve_valid & ~w_empty;
  assign w_wrong      = (w_head_pred != resolve_taken) |
                        (w_head_pred & resolve_taken & (w_head_tgt != resolve_target));
  assign w_flush      = w_do_resolve & w_wrong;
  assign w_pop        = w_do_resolve & ~w_wrong;
  // A pop frees a slot in the same cycle; a flush makes any push wrong-path.
  assign w_do_push    = push & (~w_full | w_pop) & ~w_flush;

  assign full  = w_full;
  assign empty = w_empty;
  assign count = r_count;

  // Entry storage carries no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_pc[r_wr]   <= push_pc;
      r_pred[r_wr] <= push_pred;
      r_tgt[r_wr]  <= push_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_pop)     r_rd <= r_rd + PW'(1);
      if (w_do_push) r_wr <= r_wr + PW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken         <= 1'b0;
      not_taken     <= 1'b0;
      mispredict    <= 1'b0;
      redirect_pc   <= 16'h0000;
      underflow_err <= 1'b0;
    end else begin
      taken      <= w_do_resolve & resolve_taken;
      not_taken  <= w_do_resolve & ~resolve_taken;
      mispredict <= w_flush;
      if (w_flush) begin
        redirect_pc <= resolve_taken ? resolve_target : w_head_pc + 16'd2;
      end
      if (resolve_valid & w_empty) underflow_err <= 1'b1;
    end
  end

`ifdef BR_RESOLVE_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_resolved   <= 16'h0000;
      stat_mispredict <= 16'h0000;
    end else begin
      if (w_do_resolve && stat_resolved != 16'hFFFF) stat_resolved <= stat_resolved + 16'd1;
      if (w_flush && stat_mispredict != 16'hFFFF) stat_mispredict <= stat_mispredict + 16'd1;
    end
  end
`else
  assign stat_resolved   = 16'h0000;
  assign stat_mispredict = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: directed cases then random traffic vs a queue model.
module tb_branch_resolve_queue;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push = 1'b0;
  logic [15:0] push_pc = '0;
  logic        push_pred = 1'b0;
  logic [15:0] push_target = '0;
  logic        resolve_valid = 1'b0;
  logic        resolve_taken = 1'b0;
  logic [15:0] resolve_target = '0;
  logic        taken, not_taken, mispredict, full, empty, underflow_err;
  logic [15:0] redirect_pc, stat_resolved, stat_mispredict;
  logic [$clog2(DEPTH):0] count;

  branch_resolve_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .push_pc(push_pc), .push_pred(push_pred),
    .push_target(push_target), .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target), .taken(taken), .not_taken(not_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .full(full), .empty(empty),
    .count(count), .underflow_err(underflow_err), .stat_resolved(stat_resolved),
    .stat_mispredict(stat_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] pc; bit pred; logic [15:0] tgt; } entry_t;
  typedef struct { int due; bit t; bit nt; bit mp; logic [15:0] rd; } exp_t;

  entry_t mq[$];
  exp_t   sb[$];
  bit     m_uf;
  int     m_res, m_mis;
  int     cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares pulses against the scoreboard entry due this cycle, else expects silence.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("taken", int'(taken), int'(e.t));
        chk("not_taken", int'(not_taken), int'(e.nt));
        chk("mispredict", int'(mispredict), int'(e.mp));
        if (e.mp) chk("redirect_pc", int'(redirect_pc), int'(e.rd));
      end else begin
        chk("idle_pulses", int'({taken, not_taken, mispredict}), 0);
      end
    end
  end

  task automatic check_state();
    chk("count", int'(count), mq.size());
    chk("full", int'(full), int'(mq.size() == DEPTH));
    chk("empty", int'(empty), int'(mq.size() == 0));
    chk("underflow_err", int'(underflow_err), int'(m_uf));
  endtask

  // One cycle of stimulus, issued just after a rising edge; model advances alongside.
  task automatic step(input bit p, input logic [15:0] pc, input bit pr, input logic [15:0] pt,
                      input bit rv, input bit rt, input logic [15:0] rtg);
    check_state();
    push = p; push_pc = pc; push_pred = pr; push_target = pt;
    resolve_valid = rv; resolve_taken = rt; resolve_target = rtg;
    if (rv && mq.size() == 0) begin
      m_uf = 1'b1;
      if (p) mq.push_back('{pc, pr, pt});
    end else if (rv) begin
      entry_t h;
      exp_t   e;
      bit     wrong;
      logic [15:0] seq;
      h = mq[0];
      wrong = (h.pred != rt) || (h.pred && rt && h.tgt != rtg);
      seq = h.pc + 16'd2;
      e.due = cyc + 1; e.t = rt; e.nt = !rt; e.mp = wrong; e.rd = rt ? rtg : seq;
      sb.push_back(e);
      if (m_res < 65535) m_res++;
      if (wrong && m_mis < 65535) m_mis++;
      if (wrong) mq.delete();
      else begin
        void'(mq.pop_front());
        if (p) mq.push_back('{pc, pr, pt});
      end
    end else if (p && mq.size() < DEPTH) begin
      mq.push_back('{pc, pr, pt});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats();
`ifdef BR_RESOLVE_STATS_EN
    chk("stat_resolved", int'(stat_resolved), m_res);
    chk("stat_mispredict", int'(stat_mispredict), m_mis);
`else
    chk("stat_resolved", int'(stat_resolved), 0);
    chk("stat_mispredict", int'(stat_mispredict), 0);
`endif
  endtask

  // Asynchronous reset applied mid-cycle; effects checked before the next edge.
  task automatic do_reset();
    push = 1'b0; resolve_valid = 1'b0;
    rst = 1'b1;
    #1;
    mq.delete(); sb.delete(); m_uf = 1'b0; m_res = 0; m_mis = 0;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_underflow", int'(underflow_err), 0);
    chk("rst_pulses", int'({taken, not_taken, mispredict}), 0);
    check_stats();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle();
    step(0, 16'h0, 0, 16'h0, 0, 0, 16'h0);
  endtask

  initial begin
    m_uf = 0; m_res = 0; m_mis = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_redirect", int'(redirect_pc), 0);
    do_reset();

    // Correct not-taken, then three kinds of misprediction
    step(1, 16'h3000, 0, 16'h0, 0, 0, 16'h0);
    step(0, 16'h0, 0, 16'h0, 1, 0, 16'h0);
    idle();
    step(1, 16'h3000, 0, 16'h0, 0, 0, 16'h0);
    step(0, 16'h0, 0, 16'h0, 1, 1, 16'h3040);
    idle();
    step(1, 16'h3010, 1, 16'h3100, 0, 0, 16'h0);
    step(0, 16'h0, 0, 16'h0, 1, 0, 16'h0);
    idle();
    step(1, 16'h3010, 1, 16'h3100, 0, 0, 16'h0);
    step(0, 16'h0, 0, 16'h0, 1, 1, 16'h3104);
    idle();
    // Wrap of pc+2
    step(1, 16'hFFFE, 1, 16'h1234, 0, 0, 16'h0);
    step(0, 16'h0, 0, 16'h0, 1, 0, 16'h0);
    idle();

    // Fill, overflow push, push+pop while full, flush with push
    for (int i = 0; i < DEPTH; i++) step(1, 16'h4000 + 16'(i * 2), 0, 16'h0, 0, 0, 16'h0);
    step(1, 16'h4100, 0, 16'h0, 0, 0, 16'h0);
    step(1, 16'h4200, 0, 16'h0, 1, 0, 16'h0);
    step(1, 16'h4300, 0, 16'h0, 1, 1, 16'h5000);
    step(1, 16'h4400, 1, 16'h4480, 0, 0, 16'h0);
    step(0, 16'h0, 0, 16'h0, 1, 1, 16'h4480);
    idle();

    // Underflow, then reset mid-stream with entries in flight
    step(0, 16'h0, 0, 16'h0, 1, 1, 16'h0);
    for (int i = 0; i < 3; i++) step(1, 16'h6000 + 16'(i * 2), 0, 16'h0, 0, 0, 16'h0);
    step(0, 16'h0, 0, 16'h0, 1, 0, 16'h0);
    do_reset();

    // Two resolves, one wrong
    step(1, 16'h7000, 0, 16'h0, 0, 0, 16'h0);
    step(1, 16'h7002, 1, 16'h7100, 1, 0, 16'h0);
    step(0, 16'h0, 0, 16'h0, 1, 1, 16'h7104);
    idle();
    check_stats();

    // Random traffic biased toward correct predictions so the queue fills
    for (int n = 0; n < 3000; n++) begin
      bit p, pr, rv, rt;
      logic [15:0] pc, pt, rtg;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        continue;
      end
      p  = ($urandom_range(0, 99) < 60);
      pr = $urandom_range(0, 1);
      pc = 16'($urandom_range(0, 32767) * 2);
      pt = 16'h8000 + 16'($urandom_range(0, 3) * 4);
      rv = ($urandom_range(0, 99) < 45);
      rt = $urandom_range(0, 1);
      rtg = 16'h8000 + 16'($urandom_range(0, 3) * 4);
      if (mq.size() > 0 && $urandom_range(0, 9) < 8) begin
        rt = mq[0].pred;
        rtg = mq[0].tgt;
      end
      step(p, pc, pr, pt, rv, rt, rtg);
    end
    idle();
    idle();
    check_stats();
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
